// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// Pipeline register between the ALU (EX) and the memory stage (MEM).
// It captures the ALU result and per-instruction control, detects the
// overflow / load-address / store-address exceptions, issues the data SRAM
// request for loads and stores, and hands the registered instruction to MEM
// through a valid/ready handshake. A forwarding port feeds decode.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   in_valid / in_ready    EX-side handshake
//   alu_result, alu_overflow, ov_en, in_pc, in_dest, in_gr_we,
//   in_mem_re, in_mem_we, in_mem_size, in_st_data   instruction from EX
//   flush                  exception/eret flush from WB
//   out_valid / out_ready  MEM-side handshake
//   out_pc, out_result, out_dest, out_gr_we, out_mem_re,
//   out_ex, out_excode, out_badvaddr                 registered instruction
//   data_sram_en/wen/addr/wdata                      data SRAM request
//   fwd_valid, fwd_dest, fwd_data, fwd_is_load       forwarding to decode
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  ov_en,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [4:0]            in_dest,
  input  logic                  in_gr_we,
  input  logic                  in_mem_re,
  input  logic                  in_mem_we,
  input  logic [1:0]            in_mem_size,
  input  logic [DATA_WIDTH-1:0] in_st_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [4:0]            out_dest,
  output logic                  out_gr_we,
  output logic                  out_mem_re,
  output logic                  out_ex,
  output logic [4:0]            out_excode,
  output logic [DATA_WIDTH-1:0] out_badvaddr,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_wen,
  output logic [DATA_WIDTH-1:0] data_sram_addr,
  output logic [DATA_WIDTH-1:0] data_sram_wdata,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_dest,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_is_load
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_SQUASH = 1'b1;

  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  logic                  r_state;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_result;
  logic [4:0]            r_dest;
  logic                  r_grWe;
  logic                  r_memRe;
  logic                  r_ex;
  logic [4:0]            r_excode;
  logic [DATA_WIDTH-1:0] r_badVaddr;

  logic                  w_inReady;
  logic                  w_accept;
  logic                  w_run;
  logic                  w_take;
  logic                  w_exOv;
  logic                  w_misalign;
  logic                  w_exAdel;
  logic                  w_exAdes;
  logic                  w_exAny;
  logic [4:0]            w_excode;
  logic [3:0]            w_laneMask;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_inReady = !r_outValid || out_ready;
  assign w_accept  = in_valid && w_inReady;
  assign w_run     = (r_state == ST_RUN);
  // An accepted instruction only enters the register when we are not
  // squashing and no flush is cancelling it in the same cycle.
  assign w_take    = w_accept && w_run && !flush;

  // Size code 3 is handled exactly like a word access.
  assign w_exOv     = ov_en && alu_overflow;
  assign w_misalign = ((in_mem_size == 2'd1) && alu_result[0]) ||
                      (in_mem_size[1] && (alu_result[1:0] != 2'b00));
  assign w_exAdel   = !w_exOv && in_mem_re && w_misalign;
  assign w_exAdes   = !w_exOv && in_mem_we && w_misalign;
  assign w_exAny    = w_exOv || w_exAdel || w_exAdes;

  always_comb begin
    w_excode = 5'h00;
    if (w_exOv)        w_excode = EXC_OV;
    else if (w_exAdel) w_excode = EXC_ADEL;
    else if (w_exAdes) w_excode = EXC_ADES;
  end

  always_comb begin
    w_laneMask = 4'b0000;
    w_wdata    = in_st_data;
    case (in_mem_size)
      2'd0: begin
        w_laneMask = 4'b0001 << alu_result[1:0];
        w_wdata    = {4{in_st_data[7:0]}};
      end
      2'd1: begin
        w_laneMask = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{in_st_data[15:0]}};
      end
      default: begin
        w_laneMask = 4'b1111;
        w_wdata    = in_st_data;
      end
    endcase
  end

  // The resetn term keeps the SRAM quiet while reset is held, even though
  // the empty register would otherwise accept whatever EX is presenting.
  assign data_sram_en    = resetn && w_take && (in_mem_re || in_mem_we) && !w_exAny;
  assign data_sram_wen   = (data_sram_en && in_mem_we) ? w_laneMask : 4'b0000;
  assign data_sram_addr  = {alu_result[DATA_WIDTH-1:2], 2'b00};
  assign data_sram_wdata = w_wdata;

  // Valid bit and squash state. Flush wins over everything; once an
  // excepting instruction is taken, later ones are dropped until a flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outValid <= 1'b0;
      r_state    <= ST_RUN;
    end else begin
      if (flush) begin
        r_outValid <= 1'b0;
      end else if (w_inReady) begin
        r_outValid <= w_accept && w_run;
      end
      if (flush) begin
        r_state <= ST_RUN;
      end else if (w_take && w_exAny) begin
        r_state <= ST_SQUASH;
      end
    end
  end

  // Instruction payload; it only changes when a new instruction is taken,
  // so it stays stable while MEM back-pressures.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= '0;
      r_result   <= '0;
      r_dest     <= 5'd0;
      r_grWe     <= 1'b0;
      r_memRe    <= 1'b0;
      r_ex       <= 1'b0;
      r_excode   <= 5'h00;
      r_badVaddr <= '0;
    end else if (w_take) begin
      r_pc       <= in_pc;
      r_result   <= alu_result;
      r_dest     <= in_dest;
      r_grWe     <= in_gr_we && !w_exAny;
      r_memRe    <= in_mem_re;
      r_ex       <= w_exAny;
      r_excode   <= w_excode;
      r_badVaddr <= w_exAny ? alu_result : '0;
    end
  end

  assign in_ready     = w_inReady;
  assign out_valid    = r_outValid;
  assign out_pc       = r_pc;
  assign out_result   = r_result;
  assign out_dest     = r_dest;
  assign out_gr_we    = r_grWe;
  assign out_mem_re   = r_memRe;
  assign out_ex       = r_ex;
  assign out_excode   = r_excode;
  assign out_badvaddr = r_badVaddr;

  assign fwd_valid   = r_outValid && r_grWe && (r_dest != 5'd0);
  assign fwd_dest    = r_dest;
  assign fwd_data    = r_result;
  assign fwd_is_load = r_memRe;

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline stage directly downstream of the ALU.
- Captures the ALU Result and Overflow flag together with per-instruction control, and detects Ov/AdEL/AdES exceptions.
- Issues the data-SRAM request for loads and stores, and presents the registered instruction to the MEM stage through a valid/ready handshake.
- Provides a forwarding port back to decode.

Parameters:
- DATA_WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  EX holds a valid instruction
- in_ready  out  1  this stage can accept
- alu_result  in  32  ALU Result
- alu_overflow  in  1  ALU Overflow
- ov_en  in  1  instruction traps on overflow (add/addi/sub)
- in_pc  in  32  instruction PC
- in_dest  in  5  destination GPR
- in_gr_we  in  1  writes GPR
- in_mem_re  in  1  load
- in_mem_we  in  1  store
- in_mem_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- in_st_data  in  32  store data, right-aligned
- flush  in  1  exception/eret flush from WB
- out_valid  out  1  MEM-side valid
- out_ready  in  1  MEM stage accepts
- out_pc  out  32  registered PC
- out_result  out  32  registered alu_result
- out_dest  out  5  registered destination
- out_gr_we  out  1  registered GPR write enable, forced 0 on exception
- out_mem_re  out  1  registered load flag
- out_ex  out  1  exception flag
- out_excode  out  5  0x0C Ov, 0x04 AdEL, 0x05 AdES
- out_badvaddr  out  32  faulting address
- data_sram_en  out  1  SRAM request strobe
- data_sram_wen  out  4  byte-lane write enables
- data_sram_addr  out  32  word-aligned address
- data_sram_wdata  out  32  lane-replicated store data
- fwd_valid  out  1  forwarding entry valid
- fwd_dest  out  5  forwarding destination
- fwd_data  out  32  forwarding data
- fwd_is_load  out  1  value not yet available; decode must stall

Behaviour:
- Reset (resetn=0, asynchronous): all registered outputs are 0, out_valid=0, FSM=RUN. Combinational outputs follow from these values.
- in_ready = !out_valid || out_ready.
- Accept condition: accept = in_valid && in_ready. On accept, the register loads on the next rising edge. Zero added latency, one register stage.
- out_valid next-state:
  - 0 on flush.
  - Otherwise, when in_ready, takes accept && FSM==RUN.
  - Otherwise holds.
- While out_valid=1 && out_ready=0, all out_* registers are held stable.
- Exception detect (combinational on inputs, evaluated in priority order):
  - ex_ov = ov_en && alu_overflow.
  - misalign = (size==half && a[0]) || (size==word && a[1:0]!=0), where a = alu_result.
  - ex_adel = !ex_ov && in_mem_re && misalign.
  - ex_ades = !ex_ov && in_mem_we && misalign.
  - On an exception, out_ex=1, out_gr_we=0, out_excode per the codes above, out_badvaddr=alu_result. Otherwise out_badvaddr=0.
- SRAM request:
  - data_sram_en = accept && FSM==RUN && !flush && (in_mem_re || in_mem_we) && !ex_any.
  - data_sram_addr = {alu_result[31:2], 2'b00}.
  - data_sram_wen, stores only:
    - byte: 1 << a[1:0]
    - half: a[1] ? 4'b1100 : 4'b0011
    - word: 4'b1111
    - 0 when not a store or when data_sram_en=0.
  - data_sram_wdata: byte data replicated x4, half data replicated x2, word data as is.
- FSM, two states:
  - RUN → SQUASH on accept of an instruction with ex_any (the excepting instruction itself still passes through).
  - In SQUASH, accepted instructions are dropped: they do not set out_valid and issue no SRAM request.
  - SQUASH → RUN only on flush.
  - Flush in RUN stays in RUN.
  - Flush has priority over a simultaneous accept: that instruction is dropped.
- Forwarding:
  - fwd_valid = out_valid && out_gr_we && out_dest!=0.
  - fwd_dest = out_dest.
  - fwd_data = out_result.
  - fwd_is_load = out_mem_re.
- Overflow with in_gr_we=1: GPR write suppressed via out_gr_we=0.
- resetn deasserted mid-transfer: state is lost and no SRAM request is issued during reset.

Test Plan:
- Reset then alu_result=0x1234, in_gr_we=1, dest=5, out_ready=1 → next cycle out_valid=1, out_result=0x1234, fwd_valid=1, fwd_dest=5.
- Store byte, alu_result=0x1003, st_data=0xAB → data_sram_en=1, addr=0x1000, wen=4'b1000, wdata=0xABABABAB.
- Load word at 0x1002 → out_ex=1, excode=0x04, badvaddr=0x1002, data_sram_en=0, FSM=SQUASH; the following instruction is dropped until flush=1, after which the next instruction flows normally.
- ov_en=1, alu_overflow=1, in_gr_we=1 → out_ex=1, excode=0x0C, out_gr_we=0. Same stimulus with ov_en=0 → out_ex=0, out_gr_we=1.
- out_ready held 0 for 3 cycles with out_valid=1 → in_ready=0 and outputs stable. When out_ready=1, a queued in_valid is accepted the same cycle.
- flush coincident with an accepted store → no SRAM request, out_valid=0 next cycle.
